// File: rtl/rom_16x16.sv
// Synchronous 16x16 constant store: registered read data, valid strobe and
// even-parity bit, one cycle after an enabled read.
module rom_16x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  addr,
  output logic [15:0] data,
  output logic        valid,
  output logic        parity
);

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] rom_word_s;
  logic              rom_par_s;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              parity_r;

  function automatic logic [DATA_W-1:0] rom_lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    case (a)
      4'h0:    w = 16'h0000;
      4'h1:    w = 16'h1234;
      4'h2:    w = 16'h5678;
      4'h3:    w = 16'h9ABC;
      4'h4:    w = 16'hDEF0;
      4'h5:    w = 16'hFFFF;
      4'h6:    w = 16'hAAAA;
      4'h7:    w = 16'h5555;
      4'h8:    w = 16'h8001;
      4'h9:    w = 16'h7FFE;
      4'hA:    w = 16'h00FF;
      4'hB:    w = 16'hFF00;
      4'hC:    w = 16'h0F0F;
      4'hD:    w = 16'hF0F0;
      4'hE:    w = 16'hCAFE;
      4'hF:    w = 16'hBEEF;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  // Table lookup and parity for the presented address.
  always_comb begin
    rom_word_s = rom_lookup(addr);
    rom_par_s  = even_parity(rom_word_s);
  end

  // Output register; reset wins over a read issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= 16'h0000;
      valid_r  <= 1'b0;
      parity_r <= 1'b0;
    end else if (en) begin
      data_r   <= rom_word_s;
      valid_r  <= 1'b1;
      parity_r <= rom_par_s;
    end else begin
      valid_r  <= 1'b0;
    end
  end

  assign data   = data_r;
  assign valid  = valid_r;
  assign parity = parity_r;

  logic unused_s;
  assign unused_s = (DEPTH == 16) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_rom_16x16.sv
// Directed and random self-checking bench for rom_16x16.
module tb_rom_16x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  addr;
  logic [15:0] data;
  logic        valid;
  logic        parity;

  int errors = 0;
  int checks = 0;

  logic [15:0] rom_tab [16] = '{16'h0000, 16'h1234, 16'h5678, 16'h9ABC,
                                16'hDEF0, 16'hFFFF, 16'hAAAA, 16'h5555,
                                16'h8001, 16'h7FFE, 16'h00FF, 16'hFF00,
                                16'h0F0F, 16'hF0F0, 16'hCAFE, 16'hBEEF};
  // Hand-computed parity per address: 1 at 1, 3, E, F.
  logic [15:0] par_tab = 16'b1100_0000_0000_1010;

  logic [15:0] m_data;
  logic        m_valid;
  logic        m_par;

  rom_16x16 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .addr   (addr),
    .data   (data),
    .valid  (valid),
    .parity (parity)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] d_exp,
                     input logic v_exp, input logic p_exp);
    checks++;
    assert (data === d_exp) else begin
      errors++;
      $error("FAIL %s data: got %h expected %h", tag, data, d_exp);
    end
    checks++;
    assert (valid === v_exp) else begin
      errors++;
      $error("FAIL %s valid: got %b expected %b", tag, valid, v_exp);
    end
    checks++;
    assert (parity === p_exp) else begin
      errors++;
      $error("FAIL %s parity: got %b expected %b", tag, parity, p_exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; addr = 4'h5;
    tick(); chk("reset1", 16'h0000, 1'b0, 1'b0);
    tick(); chk("reset2", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b0;
    tick(); chk("release", 16'h0000, 1'b0, 1'b0);

    en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      tick();
      chk($sformatf("sweep%0d", a), rom_tab[a], 1'b1, par_tab[a]);
    end
    addr = 4'h3; tick(); chk("addr3", 16'h9ABC, 1'b1, 1'b1);
    addr = 4'h1; tick(); chk("addr1", 16'h1234, 1'b1, 1'b1);
    addr = 4'h8; tick(); chk("addr8", 16'h8001, 1'b1, 1'b0);

    addr = 4'hE; tick(); chk("hold_rd", 16'hCAFE, 1'b1, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 4'(i * 5);
      tick();
      chk($sformatf("hold%0d", i), 16'hCAFE, 1'b0, 1'b1);
    end

    rst = 1'b1; en = 1'b1; addr = 4'hF;
    tick(); chk("rst_prio", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk("rerun", 16'hBEEF, 1'b1, 1'b1);

    m_data = 16'hBEEF; m_valid = 1'b1; m_par = 1'b1;
    for (int c = 0; c < 200; c++) begin
      rst  = ($urandom_range(0, 19) == 0);
      en   = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      if (rst) begin
        m_data = 16'h0000; m_valid = 1'b0; m_par = 1'b0;
      end else if (en) begin
        m_data = rom_tab[addr]; m_valid = 1'b1; m_par = par_tab[addr];
      end else begin
        m_valid = 1'b0;
      end
      tick();
      chk($sformatf("rand%0d", c), m_data, m_valid, m_par);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
